// File: rtl/alu_issue_seq_if.sv
// Handshake and ALU-side signal bundle for alu_issue_seq.
// slave is the sequencer view; master is the surrounding pipeline/ALU view.
interface alu_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;

    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_cntl;
    logic [2:0]  alu_funct;
    logic [31:0] alu_result;
    logic        alu_exe_branch;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5,
        input  rs1_val, rs2_val, imm, pc,
        input  alu_result, alu_exe_branch, out_ready,
        output in_ready, alu_op1, alu_op2, alu_cntl, alu_funct,
        output out_valid, wb_data, wb_en,
        output branch_taken, branch_target, illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5,
        output rs1_val, rs2_val, imm, pc,
        output alu_result, alu_exe_branch, out_ready,
        input  in_ready, alu_op1, alu_op2, alu_cntl, alu_funct,
        input  out_valid, wb_data, wb_en,
        input  branch_taken, branch_target, illegal
    );
endinterface

// File: rtl/alu_issue_seq.sv
// RV32I ALU issue sequencer: decode -> issue reg -> ALU -> output record.
// Optional macro ALU_SEQ_BRANCH_TARGET_EN adds a registered pc+imm target.
module alu_issue_seq (
    input logic            clk,
    input logic            rst_n,
    alu_issue_seq_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_XOR = 4'b0010;
    localparam logic [3:0] C_SLL = 4'b0011;
    localparam logic [3:0] C_SRL = 4'b0100;
    localparam logic [3:0] C_SRA = 4'b0101;
    localparam logic [3:0] C_ADD = 4'b0110;
    localparam logic [3:0] C_SUB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  cntl;
        logic [2:0]  funct;
        logic        wb;
        logic        br;
        logic        slt;
        logic        ill;
        logic [31:0] tgt;
    } iss_t;

    state_e state_q, state_d;
    iss_t   dec_d, iss_q;

    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] tgt_q;
    logic        wb_en_q, taken_q, ill_q;
    logic        taken_d;
    logic        rdy;
    logic        accept;

    logic        is_op, is_imm, is_br, is_lui, is_auipc;
    logic [4:0]  shamt;
    logic [31:0] src2;

    assign is_op    = bus.opcode == OPC_OP;
    assign is_imm   = bus.opcode == OPC_IMM;
    assign is_br    = bus.opcode == OPC_BR;
    assign is_lui   = bus.opcode == OPC_LUI;
    assign is_auipc = bus.opcode == OPC_AUIPC;

    assign src2  = is_op ? bus.rs2_val : bus.imm;
    assign shamt = src2[4:0];

    always_comb begin
        dec_d = '0;
        unique case (1'b1)
            is_op, is_imm: begin
                dec_d.op1   = bus.rs1_val;
                dec_d.op2   = src2;
                dec_d.funct = bus.funct3;
                dec_d.wb    = 1'b1;
                unique case (bus.funct3)
                    3'b000: dec_d.cntl =
                        (is_op & bus.funct7_5) ? C_SUB : C_ADD;
                    3'b001: begin
                        dec_d.cntl = C_SLL;
                        dec_d.op2  = {27'b0, shamt};
                    end
                    3'b010: begin
                        dec_d.cntl  = C_SUB;
                        dec_d.funct = 3'b100;
                        dec_d.slt   = 1'b1;
                    end
                    3'b011: begin
                        dec_d.cntl  = C_SUB;
                        dec_d.funct = 3'b110;
                        dec_d.slt   = 1'b1;
                    end
                    3'b100: dec_d.cntl = C_XOR;
                    3'b101: begin
                        dec_d.cntl = bus.funct7_5 ? C_SRA : C_SRL;
                        dec_d.op2  = {27'b0, shamt};
                    end
                    3'b110: dec_d.cntl = C_OR;
                    3'b111: dec_d.cntl = C_AND;
                endcase
            end
            is_br: begin
                // BRANCH funct3 010/011 have no compare encoding
                if (bus.funct3[2:1] == 2'b01) begin
                    dec_d.ill = 1'b1;
                end else begin
                    dec_d.op1   = bus.rs1_val;
                    dec_d.op2   = bus.rs2_val;
                    dec_d.cntl  = C_SUB;
                    dec_d.funct = bus.funct3;
                    dec_d.br    = 1'b1;
`ifdef ALU_SEQ_BRANCH_TARGET_EN
                    dec_d.tgt   = bus.pc + bus.imm;
`else
                    dec_d.tgt   = 32'b0;
`endif
                end
            end
            is_lui: begin
                dec_d.op2  = bus.imm;
                dec_d.cntl = C_ADD;
                dec_d.wb   = 1'b1;
            end
            is_auipc: begin
                dec_d.op1  = bus.pc;
                dec_d.op2  = bus.imm;
                dec_d.cntl = C_ADD;
                dec_d.wb   = 1'b1;
            end
            default: dec_d.ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) state_d = EXEC;
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                if (bus.out_ready) begin
                    rdy     = 1'b1;
                    state_d = bus.in_valid ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.in_valid & rdy;

    always_comb begin
        wb_data_d = bus.alu_result;
        if (iss_q.slt) wb_data_d = {31'b0, bus.alu_exe_branch};
        if (iss_q.br | iss_q.ill) wb_data_d = 32'b0;
        taken_d = iss_q.br & bus.alu_exe_branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) iss_q <= dec_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            taken_q   <= 1'b0;
            ill_q     <= 1'b0;
            tgt_q     <= '0;
        end else if (state_q == EXEC) begin
            wb_data_q <= wb_data_d;
            wb_en_q   <= iss_q.wb;
            taken_q   <= taken_d;
            ill_q     <= iss_q.ill;
            tgt_q     <= iss_q.tgt;
        end
    end

    assign bus.in_ready      = rdy;
    assign bus.out_valid     = state_q == HOLD;
    assign bus.alu_op1       = iss_q.op1;
    assign bus.alu_op2       = iss_q.op2;
    assign bus.alu_cntl      = iss_q.cntl;
    assign bus.alu_funct     = iss_q.funct;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_en         = wb_en_q;
    assign bus.branch_taken  = taken_q;
    assign bus.branch_target = tgt_q;
    assign bus.illegal       = ill_q;
endmodule
